ahb_rdata_secded_chk: RTL and testbench

Read-data checker that sits directly downstream of the AHB slave responder on the master side of the bus. It snoops the AHB read data phase, SECDED-decodes each 32-bit `hrdata` beat back into 26 data bits, and buffers the results in a small FIFO with a valid/ready output. It keeps saturating counters of single-bit and double-bit errors for scoreboard use. The block is a passive monitor: it never drives AHB signals and never stalls the bus.

---
 rtl/ahb_rdata_secded_chk.sv | 190 +++++++++++++++++++
 tb/tb_ahb_rdata_secded_chk.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rdata_secded_chk.sv
// Passive AHB read-data monitor: SECDED-decodes each read beat into 26 data bits and queues results.
// Latency: beat captured at edge E, written into the result FIFO at E+1.
// Backpressure: none toward AHB; when the result FIFO is full and not popping, the result is dropped and ovf is set.
//
// Ports:
//   hclk, hresetn            clock, async active-low reset
//   htrans, hwrite, hready,
//   hresp, hrdata            snooped AHB signals (never driven)
//   rd_valid/rd_ready        result FIFO head handshake
//   rd_data, rd_err          head entry: decoded D26..D1 and status (00 clean, 01 single, 10 uncorrectable, 11 bus error)
//   clr_cnt                  synchronous clear of cnt_sec, cnt_ded and ovf
//   cnt_sec, cnt_ded, ovf    saturating error counters and sticky drop flag
// Build option: define SECDED_CORRECT_EN to correct single errors; otherwise detect-only.

module ahb_rdata_secded_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic             hready,
  input  logic [1:0]       hresp,
  input  logic [31:0]      hrdata,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [25:0]      rd_data,
  output logic [1:0]       rd_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_sec,
  output logic [CNT_W-1:0] cnt_ded,
  output logic             ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Syndrome bit k covers every position n (bit n-1) whose index has bit k set,
  // parity bits included, so it equals recomputed XOR received parity.
  localparam logic [31:0] SYN_M0 = 32'h5555_5555;
  localparam logic [31:0] SYN_M1 = 32'h6666_6666;
  localparam logic [31:0] SYN_M2 = 32'h7878_7878;
  localparam logic [31:0] SYN_M3 = 32'h7F80_7F80;
  localparam logic [31:0] SYN_M4 = 32'h7FFF_8000;

  // Data positions 3, 5..7, 9..15, 17..31 packed as D26..D1.
  function automatic logic [25:0] extract(input logic [31:0] cw);
    return {cw[30:16], cw[14:8], cw[6:4], cw[2]};
  endfunction

  // ---------------------------------------------------------------------------
  // Phase tracking and capture
  // ---------------------------------------------------------------------------
  logic        addr_rd;
  logic        dphase;
  logic        cap_vld;
  logic        cap_berr;
  logic [31:0] cap_cw;

  assign addr_rd = ((htrans == 2'b10) || (htrans == 2'b11)) && !hwrite;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dphase   <= 1'b0;
      cap_vld  <= 1'b0;
      cap_berr <= 1'b0;
      cap_cw   <= '0;
    end else begin
      // Wait states freeze the pending data phase.
      if (hready) begin
        dphase <= addr_rd;
      end
      cap_vld <= dphase && hready;
      if (dphase && hready) begin
        cap_cw   <= hrdata;
        cap_berr <= (hresp != 2'b00);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [4:0]  syn;
  logic        odd;
  logic [31:0] fix_cw;
  logic [25:0] res_data;
  logic [1:0]  res_err;

  assign syn[0] = ^(cap_cw & SYN_M0);
  assign syn[1] = ^(cap_cw & SYN_M1);
  assign syn[2] = ^(cap_cw & SYN_M2);
  assign syn[3] = ^(cap_cw & SYN_M3);
  assign syn[4] = ^(cap_cw & SYN_M4);
  assign odd    = ^cap_cw;

  always_comb begin
    fix_cw = cap_cw;
`ifdef SECDED_CORRECT_EN
    // s == 0 with odd parity means P6 itself flipped: data untouched.
    if (odd && (syn != 5'd0)) begin
      fix_cw = cap_cw ^ (32'd1 << (syn - 5'd1));
    end
`endif
    res_data = extract(fix_cw);
    if (cap_berr) begin
      res_err = 2'b11;
    end else if (odd) begin
      res_err = 2'b01;
    end else if (syn != 5'd0) begin
      res_err = 2'b10;
    end else begin
      res_err = 2'b00;
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [27:0] mem [FIFO_DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = rd_valid && rd_ready;
  // When full, the slot being written is the one popped this cycle.
  assign wr_en = cap_vld && (!full || pop);

  assign rd_valid = !empty;
  assign rd_data  = mem[rp[AW-1:0]][25:0];
  assign rd_err   = mem[rp[AW-1:0]][27:26];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wp[AW-1:0]] <= {res_err, res_data};
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counters and overflow flag
  // ---------------------------------------------------------------------------
  logic sec_inc;
  logic ded_inc;
  logic drop;

  // Counting happens on push, regardless of whether the entry is kept.
  assign sec_inc = cap_vld && (res_err == 2'b01);
  assign ded_inc = cap_vld && (res_err == 2'b10);
  assign drop    = cap_vld && full && !pop;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt_sec <= '0;
      cnt_ded <= '0;
      ovf     <= 1'b0;
    end else if (clr_cnt) begin
      cnt_sec <= '0;
      cnt_ded <= '0;
      ovf     <= 1'b0;
    end else begin
      if (sec_inc && (cnt_sec != '1)) begin
        cnt_sec <= cnt_sec + 1'b1;
      end
      if (ded_inc && (cnt_ded != '1)) begin
        cnt_ded <= cnt_ded + 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_rdata_secded_chk.sv
module tb_ahb_rdata_secded_chk;

  localparam int CW = 4;

  logic          hclk;
  logic          hresetn;
  logic [1:0]    htrans;
  logic          hwrite;
  logic          hready;
  logic [1:0]    hresp;
  logic [31:0]   hrdata;
  logic          rd_valid;
  logic          rd_ready;
  logic [25:0]   rd_data;
  logic [1:0]    rd_err;
  logic          clr_cnt;
  logic [CW-1:0] cnt_sec;
  logic [CW-1:0] cnt_ded;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int pops;

`ifdef SECDED_CORRECT_EN
  localparam logic [25:0] SEC_D1   = 26'h1;
  localparam logic [25:0] SEC_D26  = 26'h200_0000;
`else
  localparam logic [25:0] SEC_D1   = 26'h0;
  localparam logic [25:0] SEC_D26  = 26'h0;
`endif

  ahb_rdata_secded_chk #(.FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hready   (hready),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .clr_cnt  (clr_cnt),
    .cnt_sec  (cnt_sec),
    .cnt_ded  (cnt_ded),
    .ovf      (ovf)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; counts handshakes that complete at this edge, then samples 1ns after.
  task automatic tick();
    if (rd_valid && rd_ready) pops++;
    @(posedge hclk);
    #1;
  endtask

  // Single NONSEQ read; returns 1ns after the push edge. clr asserts clr_cnt on the push edge.
  task automatic read_beat(input logic [31:0] cw, input logic [1:0] resp, input logic clr);
    htrans = 2'b10; hwrite = 1'b0; hready = 1'b1; hresp = 2'b00;
    tick();
    htrans = 2'b00; hrdata = cw; hresp = resp;
    tick();
    hresp = 2'b00; clr_cnt = clr;
    tick();
    clr_cnt = 1'b0;
  endtask

  // n-beat burst (NONSEQ then SEQ) with identical data, plus idle cycles to drain the pipeline.
  task automatic burst(input int n, input logic [31:0] cw);
    htrans = 2'b10; hwrite = 1'b0; hready = 1'b1; hresp = 2'b00;
    tick();
    for (int i = 1; i < n; i++) begin
      htrans = 2'b11; hrdata = cw;
      tick();
    end
    htrans = 2'b00; hrdata = cw;
    tick();
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    hresetn = 1'b0; htrans = 2'b00; hwrite = 1'b0; hready = 1'b1;
    hresp = 2'b00; hrdata = '0; rd_ready = 1'b0; clr_cnt = 1'b0; pops = 0;
    repeat (2) @(posedge hclk);
    #1;
    check("rst_valid", rd_valid, 0);
    check("rst_data",  rd_data,  0);
    check("rst_err",   rd_err,   0);
    check("rst_sec",   cnt_sec,  0);
    check("rst_ded",   cnt_ded,  0);
    check("rst_ovf",   ovf,      0);
    hresetn = 1'b1;
    tick();

    // Clean read of D1=1
    rd_ready = 1'b1;
    read_beat(32'h8000_0007, 2'b00, 1'b0);
    check("clean_valid", rd_valid, 1);
    check("clean_data",  rd_data,  26'h1);
    check("clean_err",   rd_err,   0);
    check("clean_sec",   cnt_sec,  0);
    check("clean_ded",   cnt_ded,  0);
    tick();
    check("clean_popped", rd_valid, 0);

    // Single error at position 3
    read_beat(32'h8000_0003, 2'b00, 1'b0);
    check("sec3_data", rd_data, SEC_D1);
    check("sec3_err",  rd_err,  1);
    check("sec3_cnt",  cnt_sec, 1);

    // P6 flipped: data unchanged either way
    read_beat(32'h0000_0007, 2'b00, 1'b0);
    check("p6_data", rd_data, 26'h1);
    check("p6_err",  rd_err,  1);
    check("p6_cnt",  cnt_sec, 2);

    // Clean D26 (position 31): all of P1..P5 set, P6 = 0
    read_beat(32'h4000_808B, 2'b00, 1'b0);
    check("d26_data", rd_data, 26'h200_0000);
    check("d26_err",  rd_err,  0);

    // Position 31 flipped: syndrome 31
    read_beat(32'h0000_808B, 2'b00, 1'b0);
    check("sec31_data", rd_data, SEC_D26);
    check("sec31_err",  rd_err,  1);
    check("sec31_cnt",  cnt_sec, 3);

    // Double error: raw data passes through
    read_beat(32'h8000_0004, 2'b00, 1'b0);
    check("ded_err",  rd_err,  2);
    check("ded_data", rd_data, 26'h1);
    check("ded_cnt",  cnt_ded, 1);
    check("ded_sec",  cnt_sec, 3);

    // Wait states in the data phase
    htrans = 2'b10; hwrite = 1'b0; hready = 1'b1;
    tick();
    htrans = 2'b00; hready = 1'b0; hrdata = 32'h8000_0007;
    tick();
    tick();
    check("ws_nocap", rd_valid, 0);
    hready = 1'b1;
    tick();
    check("ws_latency", rd_valid, 0);
    tick();
    check("ws_valid", rd_valid, 1);
    check("ws_data",  rd_data,  26'h1);
    check("ws_err",   rd_err,   0);

    // Bus error overrides syndrome, no counting
    read_beat(32'h8000_0003, 2'b01, 1'b0);
    check("berr_err", rd_err,  3);
    check("berr_sec", cnt_sec, 3);
    check("berr_ded", cnt_ded, 1);
    tick();

    // Overflow: six beats into a depth-4 FIFO with no consumer
    rd_ready = 1'b0;
    burst(6, 32'h0);
    check("ovf_valid", rd_valid, 1);
    check("ovf_flag",  ovf,      1);
    check("ovf_err",   rd_err,   0);
    pops = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("ovf_pops",  pops,     4);
    check("ovf_empty", rd_valid, 0);

    // Back-to-back single errors: full throughput, counter saturates
    pops = 0;
    burst(16, 32'h8000_0003);
    check("b2b_pops", pops,    16);
    check("sat_sec",  cnt_sec, 15);
    read_beat(32'h8000_0003, 2'b00, 1'b0);
    check("sat_hold", cnt_sec, 15);
    check("sat_ovf",  ovf,     1);
    tick();

    // Clear coinciding with a status-01 push
    read_beat(32'h8000_0003, 2'b00, 1'b1);
    check("clr_err", rd_err,  1);
    check("clr_sec", cnt_sec, 0);
    check("clr_ded", cnt_ded, 0);
    check("clr_ovf", ovf,     0);
    tick();

    // Reset with three entries queued
    rd_ready = 1'b0;
    burst(3, 32'h8000_0007);
    check("q3_valid", rd_valid, 1);
    hresetn = 1'b0;
    tick();
    check("rst_mid_valid", rd_valid, 0);
    hresetn = 1'b1;
    htrans = 2'b00; hready = 1'b1; hrdata = 32'h8000_0007;
    tick();
    tick();
    tick();
    check("rst_no_stale", rd_valid, 0);
    check("rst_mid_sec",  cnt_sec,  0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
